pipe_arith_hs: RTL and testbench

PIPE_ARITH_HS -- requirements
Module: pipe_arith_hs

---
 rtl/pipe_arith_hs.sv | 98 +++++++++
 tb/tb_pipe_arith_hs.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_arith_hs.sv
// Three-stage signed arithmetic pipeline F = (A+/-B) + (C+/-D) + D.
// It uses a valid/ready handshake and stalls all stages together on output backpressure.
module pipe_arith_hs #(
    parameter int N   = 10,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic [1:0]   mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] F,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   occ
);

    localparam int W      = N + 3;
    localparam int STAGES = 3;

    typedef struct packed {
        logic [W-1:0] x1;
        logic [W-1:0] x2;
        logic [W-1:0] d;
    } s1_t;

    typedef struct packed {
        logic [W-1:0] x3;
        logic [W-1:0] d;
    } s2_t;

    s1_t              s1, s1_nxt;
    s2_t              s2, s2_nxt;
    logic [STAGES:1]  vld_pipe, vld_nxt;
    logic [1:0]       occ_nxt;
    logic [W-1:0]     a_e, b_e, c_e, d_e, sum;
    logic             sum_ovf, advance;
    logic [N-1:0]     f_nxt;

    function automatic logic [W-1:0] sx(input logic [N-1:0] v);
        return {{3{v[N-1]}}, v};
    endfunction

    // A single global stall: every stage moves unless S3 holds an unaccepted result.
    assign advance   = !(vld_pipe[3] && !out_ready);
    assign in_ready  = advance;
    assign out_valid = vld_pipe[3];

    always_comb begin
        a_e       = sx(A);
        b_e       = sx(B);
        c_e       = sx(C);
        d_e       = sx(D);
        s1_nxt.x1 = mode[0] ? (a_e - b_e) : (a_e + b_e);
        s1_nxt.x2 = mode[1] ? (c_e + d_e) : (c_e - d_e);
        s1_nxt.d  = d_e;
        s2_nxt.x3 = s1.x1 + s1.x2;
        s2_nxt.d  = s1.d;
    end

    // Result fits in N bits only if bits W-1..N-1 are all copies of the sign.
    always_comb begin
        sum     = s2.x3 + s2.d;
        sum_ovf = !((&sum[W-1:N-1]) || !(|sum[W-1:N-1]));
        f_nxt   = sum[N-1:0];
        if (SAT && sum_ovf)
            f_nxt = sum[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end

    always_comb begin
        vld_nxt = {vld_pipe[2:1], in_valid};
        occ_nxt = {1'b0, vld_nxt[1]} + {1'b0, vld_nxt[2]} + {1'b0, vld_nxt[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
            F        <= '0;
            ovf      <= 1'b0;
            occ      <= 2'd0;
        end else if (advance) begin
            vld_pipe <= vld_nxt;
            s1       <= s1_nxt;
            s2       <= s2_nxt;
            F        <= f_nxt;
            ovf      <= sum_ovf;
            occ      <= occ_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_arith_hs.sv
// Scoreboard bench for pipe_arith_hs: a wrap and a saturating instance share stimulus.
// A monitor pops hand-computed expectations on every output transfer.
module tb_pipe_arith_hs;

    logic       clk, rst_n;
    logic [9:0] A, B, C, D;
    logic [1:0] mode;
    logic       in_valid, out_ready;
    logic       ir0, ir1, ov0, ov1, o0, o1;
    logic [9:0] F0, F1;
    logic [1:0] occ0, occ1;

    typedef struct {
        logic [9:0] f0;
        logic       o0;
        logic [9:0] f1;
        logic       o1;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0, n_push = 0, n_out = 0;

    pipe_arith_hs #(.N(10), .SAT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .mode(mode),
        .in_valid(in_valid), .in_ready(ir0), .F(F0), .ovf(o0),
        .out_valid(ov0), .out_ready(out_ready), .occ(occ0));

    pipe_arith_hs #(.N(10), .SAT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .mode(mode),
        .in_valid(in_valid), .in_ready(ir1), .F(F1), .ovf(o1),
        .out_valid(ov1), .out_ready(out_ready), .occ(occ1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called 1 time unit after a negedge; returns 1 time unit after the negedge following acceptance.
    task automatic issue(input logic [9:0] a, b, c, d, input logic [1:0] m,
                         input logic [9:0] f0, input logic ov_0,
                         input logic [9:0] f1, input logic ov_1, input int id);
        bit acc;
        int tries;
        exp_t e;
        A = a; B = b; C = c; D = d; mode = m; in_valid = 1'b1;
        acc = 1'b0;
        tries = 0;
        e.f0 = f0; e.o0 = ov_0; e.f1 = f1; e.o1 = ov_1; e.id = id;
        while (!acc && tries < 50) begin
            #2;
            acc = ir0;
            @(posedge clk);
            if (acc) begin
                sb.push_back(e);
                n_push++;
            end
            @(negedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: vector %0d not accepted, required acceptance within 50 cycles", id);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    // Monitor: sample just before the rising edge at which a transfer happens.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (ov0 && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got F=%0h with empty scoreboard, required none", F0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("F_wrap_v%0d", e.id), 32'(F0), 32'(e.f0));
                    chk($sformatf("ovf_wrap_v%0d", e.id), 32'(o0), 32'(e.o0));
                    chk($sformatf("valid_sat_v%0d", e.id), 32'(ov1), 32'd1);
                    chk($sformatf("F_sat_v%0d", e.id), 32'(F1), 32'(e.f1));
                    chk($sformatf("ovf_sat_v%0d", e.id), 32'(o1), 32'(e.o1));
                end
            end
        end
    end

    initial begin
        logic [9:0] fv;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; C = '0; D = '0; mode = 2'b00;
        #2;
        chk("rst_in_ready", 32'(ir0), 32'd1);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_occ", 32'(occ0), 32'd0);
        chk("rst_F", 32'(F0), 32'd0);
        chk("rst_ovf", 32'(o0), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Basic latency: first edge after reset release accepts
        issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b00, 10'd13, 0, 10'd13, 0, 1);
        chk("lat_e0", 32'(ov0), 32'd0);
        @(negedge clk); #1;
        chk("lat_e1", 32'(ov0), 32'd0);
        @(negedge clk); #1;
        chk("lat_e2", 32'(ov0), 32'd1);
        drain();

        // Back-to-back, occupancy reaches 3
        issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b00, 10'd13, 0, 10'd13, 0, 2);
        issue(10'd4, 10'd2, 10'd5, 10'd3, 2'b00, 10'd11, 0, 10'd11, 0, 3);
        issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b11, 10'd3, 0, 10'd3, 0, 4);
        chk("b2b_occ", 32'(occ0), 32'd3);
        chk("b2b_valid0", 32'(ov0), 32'd1);
        chk("b2b_F0", 32'(F0), 32'd13);
        @(negedge clk); #1;
        chk("b2b_valid1", 32'(ov0), 32'd1);
        chk("b2b_F1", 32'(F0), 32'd11);
        drain();

        // Modes, overflow and boundary vectors, streamed
        issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b01, 10'd1, 0, 10'd1, 0, 5);
        issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b10, 10'd15, 0, 10'd15, 0, 6);
        issue(10'd511, 10'd511, 10'd0, 10'd0, 2'b00, 10'h3FE, 1, 10'h1FF, 1, 7);
        issue(10'h200, 10'h200, 10'd0, 10'd0, 2'b00, 10'h000, 1, 10'h200, 1, 8);
        issue(10'd500, 10'd11, 10'd0, 10'd0, 2'b00, 10'h1FF, 0, 10'h1FF, 0, 9);
        issue(10'd500, 10'd12, 10'd0, 10'd0, 2'b00, 10'h200, 1, 10'h1FF, 1, 10);
        issue(-10'sd500, -10'sd12, 10'd0, 10'd0, 2'b00, 10'h200, 0, 10'h200, 0, 11);
        issue(-10'sd3, 10'd4, -10'sd5, -10'sd2, 2'b01, 10'h3F4, 0, 10'h3F4, 0, 12);
        issue(10'd511, 10'd511, -10'sd511, 10'd0, 2'b00, 10'h1FF, 0, 10'h1FF, 0, 13);
        drain();

        // Backpressure: 5 results, out_ready low for 4 cycles after first out_valid
        fork
            begin
                issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b00, 10'd13, 0, 10'd13, 0, 20);
                issue(10'd4, 10'd2, 10'd5, 10'd3, 2'b00, 10'd11, 0, 10'd11, 0, 21);
                issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b11, 10'd3, 0, 10'd3, 0, 22);
                issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b01, 10'd1, 0, 10'd1, 0, 23);
                issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b10, 10'd15, 0, 10'd15, 0, 24);
            end
            begin
                int t = 0;
                while (!ov0 && t < 20) begin
                    @(negedge clk); #1;
                    t++;
                end
                chk("bp_first_valid", 32'(ov0), 32'd1);
                out_ready = 1'b0;
                fv = F0;
                for (int k = 0; k < 4; k++) begin
                    #1;
                    chk($sformatf("bp_in_ready_%0d", k), 32'(ir0), 32'd0);
                    chk($sformatf("bp_occ_%0d", k), 32'(occ0), 32'd3);
                    chk($sformatf("bp_valid_%0d", k), 32'(ov0), 32'd1);
                    chk($sformatf("bp_F_stable_%0d", k), 32'(F0), 32'(fv));
                    @(negedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(n_out), 32'(n_push));

        // Reset mid-operation
        issue(10'd511, 10'd511, 10'd0, 10'd0, 2'b00, 10'h3FE, 1, 10'h1FF, 1, 30);
        issue(10'd4, 10'd2, 10'd5, 10'd3, 2'b00, 10'd11, 0, 10'd11, 0, 31);
        chk("mid_occ", 32'(occ0), 32'd2);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 32'(ov0), 32'd0);
        chk("mid_rst_occ", 32'(occ0), 32'd0);
        chk("mid_rst_F", 32'(F0), 32'd0);
        chk("mid_rst_ovf", 32'(o0), 32'd0);
        chk("mid_rst_in_ready", 32'(ir0), 32'd1);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
        end
        chk("post_rst_occ", 32'(occ0), 32'd0);
        issue(10'd5, 10'd6, 10'd2, 10'd1, 2'b11, 10'd3, 0, 10'd3, 0, 32);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("post_rst_valid", 32'(ov0), 32'd1);
        chk("post_rst_F", 32'(F0), 32'd3);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
